// File: rtl/if_id_buffer.sv
// Fetch-to-decode FIFO of {pc, instr, fault} with decoded fields; optional IF_ID_PERF_CNT_EN adds stall/bubble counters.
// Latency 1 cycle (no if_* -> id_* comb path); if_ready depends only on occupancy, a pop never frees a slot in the same cycle.
module if_id_buffer #(
   parameter int               XLEN      = 32,
   parameter int               DEPTH     = 2,
   parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       if_valid,
   output logic                       if_ready,
   input  logic [XLEN-1:0]            if_pc,
   input  logic [31:0]                if_instr,
   input  logic                       if_fault,
   input  logic                       flush,
   output logic                       id_valid,
   input  logic                       id_ready,
   output logic [XLEN-1:0]            id_pc,
   output logic [XLEN-1:0]            id_pc_plus4,
   output logic [31:0]                id_instr,
   output logic [6:0]                 id_opcode,
   output logic [4:0]                 id_rd,
   output logic [2:0]                 id_funct3,
   output logic [4:0]                 id_rs1,
   output logic [4:0]                 id_rs2,
   output logic [6:0]                 id_funct7,
   output logic                       id_fault,
   output logic [$clog2(DEPTH):0]     occupancy
`ifdef IF_ID_PERF_CNT_EN
   ,
   output logic [31:0]                stall_cycles,
   output logic [31:0]                bubble_cycles
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [XLEN-1:0] pc_mem_q    [DEPTH];
   logic [XLEN-1:0] pc_mem_d    [DEPTH];
   logic [31:0]     instr_mem_q [DEPTH];
   logic [31:0]     instr_mem_d [DEPTH];
   logic            fault_mem_q [DEPTH];
   logic            fault_mem_d [DEPTH];

   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] last_pc_q, last_pc_d;
   logic            push, pop;

   assign if_ready = (count_q != FULL_CNT);
   assign id_valid = (count_q != '0);
   assign push     = if_valid && if_ready;
   assign pop      = id_valid && id_ready;

   always_comb begin
      pc_mem_d    = pc_mem_q;
      instr_mem_d = instr_mem_q;
      fault_mem_d = fault_mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      // id_pc keeps showing the last head once the buffer drains
      last_pc_d   = id_valid ? pc_mem_q[rd_ptr_q] : last_pc_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            pc_mem_d[wr_ptr_q]    = if_pc;
            instr_mem_d[wr_ptr_q] = if_instr;
            fault_mem_d[wr_ptr_q] = if_fault;
            wr_ptr_d              = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         last_pc_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         last_pc_q <= last_pc_d;
      end
   end

   always_ff @(posedge clk) begin
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
      fault_mem_q <= fault_mem_d;
   end

   assign id_pc       = id_valid ? pc_mem_q[rd_ptr_q] : last_pc_q;
   assign id_pc_plus4 = id_pc + XLEN'(4);
   assign id_instr    = id_valid ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
   assign id_fault    = id_valid && fault_mem_q[rd_ptr_q];
   assign id_opcode   = id_instr[6:0];
   assign id_rd       = id_instr[11:7];
   assign id_funct3   = id_instr[14:12];
   assign id_rs1      = id_instr[19:15];
   assign id_rs2      = id_instr[24:20];
   assign id_funct7   = id_instr[31:25];
   assign occupancy   = count_q;

`ifdef IF_ID_PERF_CNT_EN
   logic [31:0] stall_q, stall_d;
   logic [31:0] bubble_q, bubble_d;

   always_comb begin
      stall_d  = stall_q;
      bubble_d = bubble_q;
      if (id_valid && !id_ready && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
      if (!id_valid && id_ready && !flush && (bubble_q != 32'hFFFF_FFFF)) begin
         bubble_d = bubble_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         stall_q  <= stall_d;
         bubble_q <= bubble_d;
      end
   end

   assign stall_cycles  = stall_q;
   assign bubble_cycles = bubble_q;
`endif

endmodule
